fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_unit_next_pc_sel.sv | 28 ++
 rtl/fetch_unit.sv | 55 +++++
 tb/tb_fetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction fetch stage
package fetch_pkg;
  localparam int PC_WIDTH = 32;
  localparam int IM_ADDR_WIDTH = 8;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: chooses the next fetch address (increment, branch or jump, jump first)
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] if_id_pc4,
  input  logic                if_id_valid,
  input  logic                branch_taken,
  input  logic [15:0]         branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                redirect
);
  logic take_jump, take_branch;
  logic [PC_WIDTH-1:0] br_target, j_target;
  // Redirects only count when the instruction in IF/ID is real.
  always_comb begin
    take_jump   = if_id_valid & jump;
    take_branch = if_id_valid & branch_taken;
    redirect    = take_jump | take_branch;
    pc_plus4    = pc + 32'd4;
    br_target   = if_id_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    j_target    = {if_id_pc4[31:28], jump_index, 2'b00};
    next_pc     = take_jump ? j_target : take_branch ? br_target : pc_plus4;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-cycle instruction fetch with PC and IF/ID pipeline register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              im_data,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [15:0]              branch_offset,
  input  logic                     jump,
  input  logic [25:0]              jump_index,
  output logic [IM_ADDR_WIDTH-1:0] im_addr,
  output logic [PC_WIDTH-1:0]      pc,
  output logic [31:0]              if_id_instr,
  output logic [PC_WIDTH-1:0]      if_id_pc4,
  output logic                     if_id_valid
);
  logic [PC_WIDTH-1:0] pc_plus4, next_pc;
  logic redirect;
  assign im_addr = pc[IM_ADDR_WIDTH-1:0];
  next_pc_sel u_sel (
    .pc            (pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );
  // Redirect squashes the wrong-path word and beats stall; stall alone freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= next_pc;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= next_pc;
      if_id_instr <= im_data;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 0, rst = 1, stall = 0, branch_taken = 0, jump = 0;
  logic [15:0] branch_offset = 0;
  logic [25:0] jump_index = 0;
  logic [31:0] im_data, pc, if_id_instr, if_id_pc4;
  logic [7:0] im_addr;
  logic if_id_valid;
  int errors = 0, checks = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .im_data(im_data), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .im_addr(im_addr), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;
  assign im_data = 32'hC0DE_0000 | {24'h0, im_addr};

  function automatic logic [31:0] word(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; branch_offset = 0; jump_index = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #2;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", if_id_instr, 32'h0); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected %h", if_id_pc4, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
  endtask

  task automatic test_free_run();
    do_reset();
    checks++; if (im_addr !== 8'h00) begin errors++; $display("FAIL run_addr0: got %h expected 00", im_addr); end
    tick();
    checks++; if (im_addr !== 8'h04) begin errors++; $display("FAIL run_addr1: got %h expected 04", im_addr); end
    checks++; if (if_id_instr !== word(8'h00)) begin errors++; $display("FAIL run_instr1: got %h expected %h", if_id_instr, word(8'h00)); end
    checks++; if (if_id_pc4 !== 32'h4) begin errors++; $display("FAIL run_pc4_1: got %h expected 00000004", if_id_pc4); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL run_valid1: got %b expected 1", if_id_valid); end
    tick();
    checks++; if (im_addr !== 8'h08) begin errors++; $display("FAIL run_addr2: got %h expected 08", im_addr); end
    checks++; if (if_id_instr !== word(8'h04)) begin errors++; $display("FAIL run_instr2: got %h expected %h", if_id_instr, word(8'h04)); end
  endtask

  task automatic test_ignore_when_bubble();
    do_reset();
    jump = 1; jump_index = 26'h100; branch_taken = 1; branch_offset = 16'h0040;
    tick();
    clear_inputs();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL ignore_pc: got %h expected 00000004", pc); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL ignore_valid: got %b expected 1", if_id_valid); end
  endtask

  task automatic test_branch();
    do_reset();
    run(5);
    checks++; if (if_id_pc4 !== 32'h14) begin errors++; $display("FAIL br_setup_pc4: got %h expected 00000014", if_id_pc4); end
    branch_taken = 1; branch_offset = 16'h0004;
    tick();
    clear_inputs();
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL br_pc: got %h expected 00000024", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b expected 0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL br_bubble: got %h expected 00000000", if_id_instr); end
    tick();
    checks++; if (if_id_instr !== word(8'h24)) begin errors++; $display("FAIL br_target_instr: got %h expected %h", if_id_instr, word(8'h24)); end
    checks++; if (if_id_pc4 !== 32'h28) begin errors++; $display("FAIL br_target_pc4: got %h expected 00000028", if_id_pc4); end
  endtask

  task automatic test_jump();
    do_reset();
    run(9);
    checks++; if (if_id_pc4 !== 32'h24) begin errors++; $display("FAIL j_setup_pc4: got %h expected 00000024", if_id_pc4); end
    jump = 1; jump_index = 26'h4;
    tick();
    clear_inputs();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL j_pc: got %h expected 00000010", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL j_valid: got %b expected 0", if_id_valid); end
    do_reset();
    run(9);
    jump = 1; jump_index = 26'h4; branch_taken = 1; branch_offset = 16'h0004;
    tick();
    clear_inputs();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL j_wins_pc: got %h expected 00000010", pc); end
  endtask

  task automatic test_stall();
    do_reset();
    run(2);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 00000008", i, pc); end
      checks++; if (if_id_instr !== word(8'h04)) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, if_id_instr, word(8'h04)); end
      checks++; if (if_id_pc4 !== 32'h8) begin errors++; $display("FAIL stall_pc4[%0d]: got %h expected 00000008", i, if_id_pc4); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, if_id_valid); end
    end
    stall = 0;
    tick();
    checks++; if (if_id_instr !== word(8'h08)) begin errors++; $display("FAIL release_instr: got %h expected %h", if_id_instr, word(8'h08)); end
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL release_pc: got %h expected 0000000c", pc); end
    checks++; if (if_id_pc4 !== 32'hC) begin errors++; $display("FAIL release_pc4: got %h expected 0000000c", if_id_pc4); end
  endtask

  task automatic test_stall_redirect_reset();
    do_reset();
    run(5);
    stall = 1; branch_taken = 1; branch_offset = 16'h0004;
    tick();
    branch_taken = 0;
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL stbr_pc: got %h expected 00000024", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL stbr_valid: got %b expected 0", if_id_valid); end
    do_reset();
    run(3);
    stall = 1;
    tick();
    #2 rst = 1;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h expected 00000000", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL midrst_instr: got %h expected 00000000", if_id_instr); end
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    branch_taken = 1; branch_offset = 16'hFFFE;
    tick();
    clear_inputs();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup_pc: got %h expected fffffffc", pc); end
    checks++; if (im_addr !== 8'hFC) begin errors++; $display("FAIL wrap_setup_addr: got %h expected fc", im_addr); end
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 00000000", pc); end
    checks++; if (im_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr: got %h expected 00", im_addr); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected 00000000", if_id_pc4); end
    checks++; if (if_id_instr !== word(8'hFC)) begin errors++; $display("FAIL wrap_instr: got %h expected %h", if_id_instr, word(8'hFC)); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b expected 1", if_id_valid); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ignore_when_bubble();
    test_branch();
    test_jump();
    test_stall();
    test_stall_redirect_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
